midi_poly_rx: RTL

//  Parametrised MIDI front end: serial byte receiver, status/running-status parser and
//  NUM_VOICES-slot polyphonic note table. Sits between the board midi_in pin and the
//  LED/synth logic. Supersedes the single-note LED reader: adds framing-error checks,

---
 rtl/midi_pkg.sv | 21 ++
 rtl/midi_uart_rx.sv | 81 ++++++++
 rtl/midi_poly_rx.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants and state encodings for the receiver, parser and voice table.
package midi_pkg;

  localparam logic [3:0] ST_OFF       = 4'h8;
  localparam logic [3:0] ST_ON        = 4'h9;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    WAIT_STATUS,
    WAIT_D1,
    WAIT_D2
  } parse_state_e;

endpackage

// File: rtl/midi_uart_rx.sv
// MIDI serial byte receiver: 2-flop synchroniser, start-bit glitch rejection,
// 8N1 framing with a one-cycle byte_valid or frame_err pulse per frame.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_in,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync;
  rx_state_e     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign rx_byte = shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync       <= 2'b11;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync       <= {sync[0], midi_in};
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!sync[1]) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= sync[1] ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shreg   <= {sync[1], shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_M1) begin
            cnt        <= '0;
            byte_valid <= sync[1];
            frame_err  <= !sync[1];
            state      <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/midi_poly_rx.sv
// MIDI front end: byte receiver, running-status note parser with channel filter,
// and a NUM_VOICES-slot polyphonic note table with optional voice stealing.
module midi_poly_rx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 128,
  parameter int NUM_VOICES   = 4,
  parameter bit STEAL        = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    midi_in,
  input  logic [3:0]              cfg_chan,
  input  logic                    cfg_omni,
  output logic                    ev_valid,
  output logic                    ev_on,
  output logic [6:0]              ev_note,
  output logic [6:0]              ev_vel,
  output logic [NUM_VOICES-1:0]   voice_act,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_vel,
  output logic [7:0]              led_out,
  output logic                    frame_err,
  output logic                    overflow
);

  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [7:0]   rx_byte;
  logic         byte_valid;
  parse_state_e pstate;
  logic         status_on;
  logic [6:0]   note_lat;
  logic [6:0]   note_q [NUM_VOICES];
  logic [6:0]   vel_q  [NUM_VOICES];
  logic [VW-1:0] steal_ptr;

  midi_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .midi_in    (midi_in),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  logic          ev_fire, new_on, chan_ok, hit, free;
  logic [VW-1:0] hit_idx, free_idx;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ev_fire  = byte_valid && !rx_byte[7] && (pstate == WAIT_D2);
    new_on   = status_on && (rx_byte[6:0] != 7'd0);
    chan_ok  = cfg_omni || (rx_byte[3:0] == cfg_chan);
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    // Descending scan so the lowest matching index wins.
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (voice_act[i] && note_q[i] == note_lat) begin
        hit     = 1'b1;
        hit_idx = VW'(i);
      end
      if (!voice_act[i]) begin
        free     = 1'b1;
        free_idx = VW'(i);
      end
    end
  end

  always_comb begin
    voice_note = '0;
    voice_vel  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_note[7*i +: 7] = note_q[i];
      voice_vel[7*i +: 7]  = vel_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pstate    <= WAIT_STATUS;
      status_on <= 1'b0;
      note_lat  <= '0;
      ev_valid  <= 1'b0;
      ev_on     <= 1'b0;
      ev_note   <= '0;
      ev_vel    <= '0;
      voice_act <= '0;
      steal_ptr <= '0;
      led_out   <= '0;
      overflow  <= 1'b0;
      // NOTE: the voice table is a handful of flops that must read empty after reset, so it is reset explicitly.
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
      end
    end else begin
      ev_valid <= 1'b0;
      overflow <= 1'b0;

      if (frame_err) begin
        pstate <= WAIT_STATUS;
      end else if (byte_valid && rx_byte < REALTIME_MIN) begin
        if (rx_byte[7]) begin
          if (rx_byte[7:4] == ST_ON || rx_byte[7:4] == ST_OFF) begin
            status_on <= (rx_byte[7:4] == ST_ON);
            pstate    <= chan_ok ? WAIT_D1 : WAIT_STATUS;
          end else begin
            pstate <= WAIT_STATUS;
          end
        end else begin
          case (pstate)
            WAIT_D1: begin
              note_lat <= rx_byte[6:0];
              pstate   <= WAIT_D2;
            end
            WAIT_D2: pstate <= WAIT_D1;
            default: ;
          endcase
        end
      end

      if (ev_fire) begin
        ev_valid <= 1'b1;
        ev_on    <= new_on;
        ev_note  <= note_lat;
        ev_vel   <= rx_byte[6:0];
        if (new_on) begin
          led_out <= {1'b0, note_lat};
          if (hit) begin
            vel_q[hit_idx] <= rx_byte[6:0];
          end else if (free) begin
            voice_act[free_idx] <= 1'b1;
            note_q[free_idx]    <= note_lat;
            vel_q[free_idx]     <= rx_byte[6:0];
          end else begin
            overflow <= 1'b1;
            if (STEAL) begin
              note_q[steal_ptr] <= note_lat;
              vel_q[steal_ptr]  <= rx_byte[6:0];
              steal_ptr <= (steal_ptr == VW'(NUM_VOICES - 1)) ? '0 : steal_ptr + 1'b1;
            end
          end
        end else begin
          if (hit) begin
            voice_act[hit_idx] <= 1'b0;
            note_q[hit_idx]    <= '0;
            vel_q[hit_idx]     <= '0;
          end
          if (led_out[6:0] == note_lat) led_out <= '0;
        end
      end
    end
  end

endmodule
